interval_timer: RTL and testbench
=================================

// Module: interval_timer
// PURPOSE
//  Consumer side of the time-parameter store: drives its interval select,
//  fetches the registered 4-bit duration, counts it down on the 1 s tick
//  and pulses `expired` at the end. Sits between the traffic sequencing FSM
//  (start/abort/interval_req) and the time-parameter store (intervel/time_val).
// PARAMETERS
//  TIME_W    4  width of duration value and down-counter
//  SEL_W     2  width of interval select (00 base, 01 ext, 10 yellow, 11 -> base)
//  LOAD_LAT  2  cycles in FETCH, from the intervel update to the remaining load; >=2
// PORTS
//  clk           in   1       system clock, all state on rising edge
//  reset         in   1       asynchronous, active-low reset
//  start         in   1       request a new interval; sampled only in IDLE/DONE
//  abort         in   1       cancel current interval, no expired pulse
//  interval_req  in   SEL_W   interval to time; captured with start
//  tick          in   1       1-cycle 1 s enable pulse from prescaler
//  time_val      in   TIME_W  duration from store (registered, 1-cycle latency)
//  intervel      out  SEL_W   registered select driven to store
//  busy          out  1       1 in FETCH and RUN
//  expired       out  1       1-cycle pulse: interval elapsed
//  remaining     out  TIME_W  ticks still to count (0 when idle)
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, intervel=2'b00, remaining=0,
//    busy=0, expired=0, wait counter=0. All outputs registered.
//  - States: IDLE, FETCH, RUN, DONE.
//  - IDLE: start=1 -> intervel<=interval_req, wait cnt<=0, ->FETCH.
//  - FETCH: tick ignored; wait cnt increments each cycle; on the
//    LOAD_LAT-th cycle remaining<=time_val; ->RUN if time_val!=0,
//    else ->DONE. With LOAD_LAT=2: start sampled at edge E; intervel valid
//    after E; remaining loaded at E+2; busy=1 for exactly 2 cycles before RUN.
//  - RUN: tick=1 & remaining>1 -> remaining-1. tick=1 & remaining==1 ->
//    remaining<=0, ->DONE. No tick -> hold.
//  - DONE: expired=1 for this one cycle, busy=0. start=1 here is accepted
//    (same as IDLE, -> FETCH); otherwise -> IDLE.
//  - intervel holds last requested value in all states; changes only on an
//    accepted start. 2'b11 passed through unchanged (store returns base).
//  - start while busy: ignored, no queuing.
//  - abort=1 in FETCH or RUN: -> IDLE, remaining<=0, expired stays 0.
//    abort and start in same cycle: abort wins, start dropped.
//  - abort in IDLE/DONE: no effect except cancelling a start in that cycle;
//    expired pulse in DONE still completes.
//  - Counter never wraps: decrement only when remaining>=1.
//  - Reset mid-interval: immediate return to reset values; no expired.
// STRUCTURE
//  - Shared package traffic_pkg: SEL codes (SEL_BASE=2'b00, SEL_EXT=2'b01,
//    SEL_YEL=2'b10), TIME_W, state encoding localparams for interval_timer.
//  - Single module; no sub-module. Down-counter and wait counter inline.
// TESTING
//  Bench instantiates time_parameter store (defaults base=6, ext=3, yel=2),
//  tick every 4 clk.
//  1 start, req=00 -> busy 2 cycles FETCH, remaining=6, expired pulse
//    after 6th tick, busy=0 same cycle, remaining=0.
//  2 program yel=0, start req=10 -> FETCH then DONE, expired 3 cycles
//    after start, no RUN cycles.
//  3 req=01 running, start req=10 mid-RUN -> ignored, intervel stays 01,
//    expiry after 3 ticks.
//  4 abort at remaining=4 with start same cycle -> IDLE, remaining=0,
//    no expired, intervel unchanged.
//  5 start asserted in DONE cycle with req=11 -> expired pulse still seen,
//    intervel=11, remaining=6 (base) after FETCH.
//  6 reset=0 async mid-RUN (between edges) -> outputs to reset values at
//    once; after release, idle until next start.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic controller blocks: interval select codes,
// duration width and the interval_timer state encoding.
package traffic_pkg;

   localparam int TIME_W = 4;
   localparam int SEL_W  = 2;

   localparam logic [SEL_W-1:0] SEL_BASE = 2'b00;
   localparam logic [SEL_W-1:0] SEL_EXT  = 2'b01;
   localparam logic [SEL_W-1:0] SEL_YEL  = 2'b10;

   localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
   localparam logic [1:0] ST_FETCH_ENC = 2'd1;
   localparam logic [1:0] ST_RUN_ENC   = 2'd2;
   localparam logic [1:0] ST_DONE_ENC  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = ST_IDLE_ENC,
      ST_FETCH = ST_FETCH_ENC,
      ST_RUN   = ST_RUN_ENC,
      ST_DONE  = ST_DONE_ENC
   } timer_state_e;

endpackage

// File: rtl/interval_timer_if.sv
// Signal bundle between the sequencing FSM / time-parameter store (master)
// and the interval timer (slave).
interface interval_timer_if;
   import traffic_pkg::*;

   logic              start;
   logic              abort;
   logic [SEL_W-1:0]  interval_req;
   logic              tick;
   logic [TIME_W-1:0] time_val;
   logic [SEL_W-1:0]  intervel;
   logic              busy;
   logic              expired;
   logic [TIME_W-1:0] remaining;

   modport slave (
      input  start, abort, interval_req, tick, time_val,
      output intervel, busy, expired, remaining
   );

   modport master (
      output start, abort, interval_req, tick, time_val,
      input  intervel, busy, expired, remaining
   );

endinterface

// File: rtl/interval_timer.sv
// Interval timer: selects a duration in the parameter store, waits for its
// registered value, counts it down on the 1 s tick and pulses expired.
module interval_timer
   import traffic_pkg::*;
#(
   parameter int LOAD_LAT = 2
) (
   input  logic            clk,
   input  logic            reset,
   interval_timer_if.slave bus
);

   // LOAD_LAT must be at least 2 so the store has seen the new select.
   localparam int WAIT_W = (LOAD_LAT > 2) ? $clog2(LOAD_LAT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LOAD_LAT - 1);

   timer_state_e      state_q, state_d;
   logic [SEL_W-1:0]  intervel_q, intervel_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [TIME_W-1:0] remaining_q, remaining_d;
   logic              busy_q, busy_d;
   logic              expired_q, expired_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         intervel_q  <= SEL_BASE;
         wait_q      <= '0;
         remaining_q <= '0;
         busy_q      <= 1'b0;
         expired_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         intervel_q  <= intervel_d;
         wait_q      <= wait_d;
         remaining_q <= remaining_d;
         busy_q      <= busy_d;
         expired_q   <= expired_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      intervel_d  = intervel_q;
      wait_d      = wait_q;
      remaining_d = remaining_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start && !bus.abort) begin
               intervel_d = bus.interval_req;
               wait_d     = '0;
               state_d    = ST_FETCH;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FETCH: begin
            if (bus.abort) begin
               remaining_d = '0;
               state_d     = ST_IDLE;
            end else if (wait_q == WAIT_LAST) begin
               remaining_d = bus.time_val;
               state_d     = (bus.time_val != '0) ? ST_RUN : ST_DONE;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         ST_RUN: begin
            if (bus.abort) begin
               remaining_d = '0;
               state_d     = ST_IDLE;
            end else if (bus.tick) begin
               // Guarded on >=1 so the counter can never wrap below zero.
               if (remaining_q > TIME_W'(1)) begin
                  remaining_d = remaining_q - TIME_W'(1);
               end else if (remaining_q == TIME_W'(1)) begin
                  remaining_d = '0;
                  state_d     = ST_DONE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d    = (state_d == ST_FETCH) || (state_d == ST_RUN);
      expired_d = (state_d == ST_DONE);
   end

   assign bus.intervel  = intervel_q;
   assign bus.busy      = busy_q;
   assign bus.expired   = expired_q;
   assign bus.remaining = remaining_q;

endmodule

// File: tb/tb_interval_timer.sv
// Bench for interval_timer with a behavioural time-parameter store
// (base=6, ext=3, yel=2, registered) and ticks driven every 4th clock.
module tb_interval_timer;
   import traffic_pkg::*;

   logic clk;
   logic rst_n;
   logic [TIME_W-1:0] base_t;
   logic [TIME_W-1:0] ext_t;
   logic [TIME_W-1:0] yel_t;
   int total;
   int bad;

   interval_timer_if bus ();

   interval_timer #(.LOAD_LAT(2)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Store model: one-cycle registered lookup, select 11 returns base.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.time_val <= '0;
      end else begin
         case (bus.intervel)
            SEL_EXT: bus.time_val <= ext_t;
            SEL_YEL: bus.time_val <= yel_t;
            default: bus.time_val <= base_t;
         endcase
      end
   end

   typedef struct {
      logic       start;
      logic       abort;
      logic [1:0] req;
      logic       tick;
      int         reps;
      logic       busy;
      logic       expired;
      logic [3:0] rem;
      logic [1:0] iv;
   } vec_t;

   vec_t vecs [16];

   task automatic check_output(input string name, input int actual, input int expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic check_all(input string tag, input logic b, input logic e,
                            input logic [3:0] r, input logic [1:0] iv);
      check_output({tag, " busy"}, int'(bus.busy), int'(b));
      check_output({tag, " expired"}, int'(bus.expired), int'(e));
      check_output({tag, " remaining"}, int'(bus.remaining), int'(r));
      check_output({tag, " intervel"}, int'(bus.intervel), int'(iv));
   endtask

   task automatic apply_stimulus(input logic s, input logic a, input logic [1:0] req, input logic t);
      bus.start        = s;
      bus.abort        = a;
      bus.interval_req = req;
      bus.tick         = t;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.tick  = 1'b0;
   endtask

   task automatic tick_after_gap();
      repeat (3) apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0);
      apply_stimulus(1'b0, 1'b0, 2'b00, 1'b1);
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      base_t = 4'd6;
      ext_t  = 4'd3;
      yel_t  = 4'd2;
      rst_n  = 1'b0;
      bus.start        = 1'b0;
      bus.abort        = 1'b0;
      bus.interval_req = 2'b00;
      bus.tick         = 1'b0;

      // start, abort, req, tick, reps -> busy, expired, remaining, intervel
      vecs[0]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1, 1'b1, 1'b0, 4'd0, 2'b00};
      vecs[1]  = '{1'b0, 1'b0, 2'b00, 1'b1, 1, 1'b1, 1'b0, 4'd0, 2'b00};
      vecs[2]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1, 1'b1, 1'b0, 4'd6, 2'b00};
      vecs[3]  = '{1'b0, 1'b0, 2'b00, 1'b0, 3, 1'b1, 1'b0, 4'd6, 2'b00};
      vecs[4]  = '{1'b0, 1'b0, 2'b00, 1'b1, 1, 1'b1, 1'b0, 4'd5, 2'b00};
      vecs[5]  = '{1'b0, 1'b0, 2'b00, 1'b0, 3, 1'b1, 1'b0, 4'd5, 2'b00};
      vecs[6]  = '{1'b0, 1'b0, 2'b00, 1'b1, 1, 1'b1, 1'b0, 4'd4, 2'b00};
      vecs[7]  = '{1'b0, 1'b0, 2'b00, 1'b0, 3, 1'b1, 1'b0, 4'd4, 2'b00};
      vecs[8]  = '{1'b0, 1'b0, 2'b00, 1'b1, 1, 1'b1, 1'b0, 4'd3, 2'b00};
      vecs[9]  = '{1'b0, 1'b0, 2'b00, 1'b0, 3, 1'b1, 1'b0, 4'd3, 2'b00};
      vecs[10] = '{1'b0, 1'b0, 2'b00, 1'b1, 1, 1'b1, 1'b0, 4'd2, 2'b00};
      vecs[11] = '{1'b0, 1'b0, 2'b00, 1'b0, 3, 1'b1, 1'b0, 4'd2, 2'b00};
      vecs[12] = '{1'b0, 1'b0, 2'b00, 1'b1, 1, 1'b1, 1'b0, 4'd1, 2'b00};
      vecs[13] = '{1'b0, 1'b0, 2'b00, 1'b0, 3, 1'b1, 1'b0, 4'd1, 2'b00};
      vecs[14] = '{1'b0, 1'b0, 2'b00, 1'b1, 1, 1'b0, 1'b1, 4'd0, 2'b00};
      vecs[15] = '{1'b0, 1'b0, 2'b00, 1'b0, 1, 1'b0, 1'b0, 4'd0, 2'b00};

      #12;
      check_all("reset", 1'b0, 1'b0, 4'd0, 2'b00);
      rst_n = 1'b1;

      $display("[TB] base interval countdown");
      for (int i = 0; i < 16; i++) begin
         for (int k = 0; k < vecs[i].reps; k++) begin
            apply_stimulus(vecs[i].start, vecs[i].abort, vecs[i].req, vecs[i].tick);
            check_all($sformatf("vec%0d.%0d", i, k), vecs[i].busy, vecs[i].expired,
                      vecs[i].rem, vecs[i].iv);
         end
      end

      $display("[TB] zero duration goes straight to DONE");
      yel_t = 4'd0;
      apply_stimulus(1'b1, 1'b0, 2'b10, 1'b0);
      check_all("zero fetch1", 1'b1, 1'b0, 4'd0, 2'b10);
      apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0);
      check_all("zero fetch2", 1'b1, 1'b0, 4'd0, 2'b10);
      apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0);
      check_all("zero done", 1'b0, 1'b1, 4'd0, 2'b10);
      apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0);
      check_all("zero idle", 1'b0, 1'b0, 4'd0, 2'b10);
      yel_t = 4'd2;

      $display("[TB] start while running is ignored");
      apply_stimulus(1'b1, 1'b0, 2'b01, 1'b0);
      check_all("ext fetch1", 1'b1, 1'b0, 4'd0, 2'b01);
      apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0);
      apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0);
      check_all("ext load", 1'b1, 1'b0, 4'd3, 2'b01);
      apply_stimulus(1'b1, 1'b0, 2'b10, 1'b0);
      check_all("ext busy start", 1'b1, 1'b0, 4'd3, 2'b01);
      tick_after_gap();
      check_all("ext tick1", 1'b1, 1'b0, 4'd2, 2'b01);
      tick_after_gap();
      check_all("ext tick2", 1'b1, 1'b0, 4'd1, 2'b01);
      tick_after_gap();
      check_all("ext done", 1'b0, 1'b1, 4'd0, 2'b01);
      apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0);
      check_all("ext idle", 1'b0, 1'b0, 4'd0, 2'b01);

      $display("[TB] abort beats start");
      apply_stimulus(1'b1, 1'b0, 2'b00, 1'b0);
      apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0);
      apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0);
      check_all("abort load", 1'b1, 1'b0, 4'd6, 2'b00);
      tick_after_gap();
      tick_after_gap();
      check_all("abort at4", 1'b1, 1'b0, 4'd4, 2'b00);
      apply_stimulus(1'b1, 1'b1, 2'b10, 1'b0);
      check_all("abort hit", 1'b0, 1'b0, 4'd0, 2'b00);
      apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0);
      check_all("abort after", 1'b0, 1'b0, 4'd0, 2'b00);

      $display("[TB] restart from DONE with select 11");
      apply_stimulus(1'b1, 1'b0, 2'b01, 1'b0);
      apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0);
      apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0);
      check_all("chain load", 1'b1, 1'b0, 4'd3, 2'b01);
      tick_after_gap();
      tick_after_gap();
      tick_after_gap();
      check_all("chain done", 1'b0, 1'b1, 4'd0, 2'b01);
      apply_stimulus(1'b1, 1'b0, 2'b11, 1'b0);
      check_all("chain restart", 1'b1, 1'b0, 4'd0, 2'b11);
      apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0);
      apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0);
      check_all("chain base", 1'b1, 1'b0, 4'd6, 2'b11);
      apply_stimulus(1'b0, 1'b1, 2'b00, 1'b0);
      check_all("chain abort", 1'b0, 1'b0, 4'd0, 2'b11);

      $display("[TB] asynchronous reset mid-run");
      apply_stimulus(1'b1, 1'b0, 2'b00, 1'b0);
      apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0);
      apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0);
      tick_after_gap();
      check_all("rst pre", 1'b1, 1'b0, 4'd5, 2'b00);
      apply_stimulus(1'b1, 1'b0, 2'b01, 1'b0);
      check_all("rst ignored start", 1'b1, 1'b0, 4'd5, 2'b00);
      #2;
      rst_n = 1'b0;
      #1;
      check_all("rst async", 1'b0, 1'b0, 4'd0, 2'b00);
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0);
      apply_stimulus(1'b0, 1'b0, 2'b00, 1'b1);
      check_all("rst idle", 1'b0, 1'b0, 4'd0, 2'b00);
      apply_stimulus(1'b1, 1'b0, 2'b01, 1'b0);
      check_all("rst restart", 1'b1, 1'b0, 4'd0, 2'b01);
      apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0);
      apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0);
      check_all("rst reload", 1'b1, 1'b0, 4'd3, 2'b01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
